// File: rtl/countdown_timer_if.sv
// Command/preset and display/status bundle for the mm:ss countdown timer.
interface countdown_timer_if;
   logic       load;
   logic       start;
   logic       pause;
   logic [7:0] min_in;
   logic [7:0] sec_in;
   logic [7:0] min_out;
   logic [7:0] sec_out;
   logic       running;
   logic       done;
   logic       alarm;
   logic       load_err;

   modport master (
      output load, start, pause, min_in, sec_in,
      input  min_out, sec_out, running, done, alarm, load_err
   );

   modport slave (
      input  load, start, pause, min_in, sec_in,
      output min_out, sec_out, running, done, alarm, load_err
   );
endinterface

// File: rtl/countdown_timer.sv
// Preset BCD mm:ss countdown timer with run/pause, 00:00 alarm and load validation.
// One second is CLK_HZ clk cycles, counted by a prescaler that only runs in RUN.
module countdown_timer #(
   parameter int unsigned CLK_HZ = 24_000_000
) (
   input  logic               clk,
   input  logic               res,
   countdown_timer_if.slave   bus
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state_q, state_n;
   logic [7:0]    min_q, min_n;
   logic [7:0]    sec_q, sec_n;
   logic [PW-1:0] pre_q, pre_n;
   logic          alarm_q, alarm_n;
   logic          err_q, err_n;

   logic          valid;
   logic          zero;
   logic          tick;
   logic [7:0]    dec_min, dec_sec;

   assign valid = (bus.min_in[7:4] <= 4'd9) && (bus.min_in[3:0] <= 4'd9) &&
                  (bus.sec_in[7:4] <= 4'd5) && (bus.sec_in[3:0] <= 4'd9);
   assign zero  = (min_q == 8'h00) && (sec_q == 8'h00);
   assign tick  = (state_q == RUN) && (pre_q == PRE_MAX);

   // BCD borrow chain: one-second decrement of the current count
   always_comb begin
      dec_min = min_q;
      dec_sec = sec_q;
      if (sec_q[3:0] != 4'd0) begin
         dec_sec[3:0] = sec_q[3:0] - 4'd1;
      end else begin
         dec_sec[3:0] = 4'd9;
         if (sec_q[7:4] != 4'd0) begin
            dec_sec[7:4] = sec_q[7:4] - 4'd1;
         end else begin
            dec_sec[7:4] = 4'd5;
            if (min_q[3:0] != 4'd0) begin
               dec_min[3:0] = min_q[3:0] - 4'd1;
            end else begin
               dec_min[3:0] = 4'd9;
               dec_min[7:4] = min_q[7:4] - 4'd1;
            end
         end
      end
   end

   // Next state, count, prescaler and pulse flags; load pre-empts all other commands
   always_comb begin
      state_n = state_q;
      min_n   = min_q;
      sec_n   = sec_q;
      pre_n   = pre_q;
      alarm_n = 1'b0;
      err_n   = 1'b0;
      if (bus.load) begin
         if (valid) begin
            min_n   = bus.min_in;
            sec_n   = bus.sec_in;
            pre_n   = '0;
            state_n = IDLE;
         end else begin
            err_n = 1'b1;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  pre_n = '0;
                  if (zero) begin
                     state_n = DONE;
                     alarm_n = 1'b1;
                  end else begin
                     state_n = RUN;
                  end
               end
            end
            PAUSE: begin
               // resume keeps the prescaler so a paused second finishes where it left off
               if (bus.start) begin
                  if (zero) begin
                     state_n = DONE;
                     alarm_n = 1'b1;
                  end else begin
                     state_n = RUN;
                  end
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_n = PAUSE;
               end else if (tick) begin
                  pre_n = '0;
                  min_n = dec_min;
                  sec_n = dec_sec;
                  if ((dec_min == 8'h00) && (dec_sec == 8'h00)) begin
                     state_n = DONE;
                     alarm_n = 1'b1;
                  end
               end else begin
                  pre_n = pre_q + PW'(1);
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State, count, prescaler and pulse registers
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         min_q   <= '0;
         sec_q   <= '0;
         pre_q   <= '0;
         alarm_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         min_q   <= min_n;
         sec_q   <= sec_n;
         pre_q   <= pre_n;
         alarm_q <= alarm_n;
         err_q   <= err_n;
      end
   end

   assign bus.min_out  = min_q;
   assign bus.sec_out  = sec_q;
   assign bus.running  = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.alarm    = alarm_q;
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with CLK_HZ=10.
// Snapshot layout: {min_out, sec_out, running, done, alarm, load_err}.
module tb_countdown_timer;

   logic clk = 1'b0;
   logic res;
   int   total = 0;
   int   bad   = 0;

   countdown_timer_if ifc ();

   countdown_timer #(.CLK_HZ(10)) dut (
      .clk (clk),
      .res (res),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   logic [19:0] snap;
   assign snap = {ifc.min_out, ifc.sec_out, ifc.running, ifc.done, ifc.alarm, ifc.load_err};

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      ifc.load = 1'b1;
      ifc.min_in = m;
      ifc.sec_in = s;
      step(1);
      ifc.load = 1'b0;
   endtask

   task automatic do_cmd(input logic st, input logic pa);
      ifc.start = st;
      ifc.pause = pa;
      step(1);
      ifc.start = 1'b0;
      ifc.pause = 1'b0;
   endtask

   task automatic test_reset;
      res = 1'b1;
      ifc.load = 1'b0; ifc.start = 1'b0; ifc.pause = 1'b0;
      ifc.min_in = 8'h00; ifc.sec_in = 8'h00;
      step(2);
      res = 1'b0;
      step(1);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0000}) begin
         bad++; $display("FAIL reset: got %h want %h", snap, {8'h00, 8'h00, 4'b0000});
      end
   endtask

   task automatic test_borrow;
      do_load(8'h01, 8'h00);
      do_cmd(1'b1, 1'b0);
      step(9);
      total++;
      if (snap !== {8'h01, 8'h00, 4'b1000}) begin
         bad++; $display("FAIL borrow_pre: got %h want %h", snap, {8'h01, 8'h00, 4'b1000});
      end
      step(1);
      total++;
      if (snap !== {8'h00, 8'h59, 4'b1000}) begin
         bad++; $display("FAIL borrow_0100: got %h want %h", snap, {8'h00, 8'h59, 4'b1000});
      end
      do_load(8'h10, 8'h00);
      do_cmd(1'b1, 1'b0);
      step(10);
      total++;
      if (snap !== {8'h09, 8'h59, 4'b1000}) begin
         bad++; $display("FAIL borrow_1000: got %h want %h", snap, {8'h09, 8'h59, 4'b1000});
      end
   endtask

   task automatic test_expire;
      do_load(8'h00, 8'h02);
      do_cmd(1'b1, 1'b0);
      step(19);
      total++;
      if (snap !== {8'h00, 8'h01, 4'b1000}) begin
         bad++; $display("FAIL expire_pre: got %h want %h", snap, {8'h00, 8'h01, 4'b1000});
      end
      step(1);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0110}) begin
         bad++; $display("FAIL expire_alarm: got %h want %h", snap, {8'h00, 8'h00, 4'b0110});
      end
      step(1);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0100}) begin
         bad++; $display("FAIL expire_hold: got %h want %h", snap, {8'h00, 8'h00, 4'b0100});
      end
      do_cmd(1'b1, 1'b0);
      step(5);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0100}) begin
         bad++; $display("FAIL done_start_ignored: got %h want %h", snap, {8'h00, 8'h00, 4'b0100});
      end
   endtask

   task automatic test_pause;
      do_load(8'h00, 8'h05);
      do_cmd(1'b1, 1'b0);
      step(4);
      do_cmd(1'b0, 1'b1);
      step(50);
      total++;
      if (snap !== {8'h00, 8'h05, 4'b0000}) begin
         bad++; $display("FAIL pause_frozen: got %h want %h", snap, {8'h00, 8'h05, 4'b0000});
      end
      do_cmd(1'b1, 1'b0);
      step(5);
      total++;
      if (snap !== {8'h00, 8'h05, 4'b1000}) begin
         bad++; $display("FAIL resume_pre: got %h want %h", snap, {8'h00, 8'h05, 4'b1000});
      end
      step(1);
      total++;
      if (snap !== {8'h00, 8'h04, 4'b1000}) begin
         bad++; $display("FAIL resume_dec: got %h want %h", snap, {8'h00, 8'h04, 4'b1000});
      end
      do_cmd(1'b1, 1'b1);
      total++;
      if (snap !== {8'h00, 8'h04, 4'b0000}) begin
         bad++; $display("FAIL both_in_run: got %h want %h", snap, {8'h00, 8'h04, 4'b0000});
      end
      do_cmd(1'b1, 1'b1);
      total++;
      if (snap !== {8'h00, 8'h04, 4'b1000}) begin
         bad++; $display("FAIL both_in_pause: got %h want %h", snap, {8'h00, 8'h04, 4'b1000});
      end
   endtask

   task automatic test_load_err;
      do_load(8'h00, 8'h07);
      do_load(8'h00, 8'h60);
      total++;
      if (snap !== {8'h00, 8'h07, 4'b0001}) begin
         bad++; $display("FAIL err_sec60: got %h want %h", snap, {8'h00, 8'h07, 4'b0001});
      end
      step(1);
      total++;
      if (snap !== {8'h00, 8'h07, 4'b0000}) begin
         bad++; $display("FAIL err_clear: got %h want %h", snap, {8'h00, 8'h07, 4'b0000});
      end
      do_load(8'h1A, 8'h00);
      total++;
      if (snap !== {8'h00, 8'h07, 4'b0001}) begin
         bad++; $display("FAIL err_min1a: got %h want %h", snap, {8'h00, 8'h07, 4'b0001});
      end
      do_load(8'h00, 8'h00);
      do_cmd(1'b1, 1'b0);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0110}) begin
         bad++; $display("FAIL start_zero: got %h want %h", snap, {8'h00, 8'h00, 4'b0110});
      end
   endtask

   task automatic test_reset_run;
      do_load(8'h03, 8'h17);
      do_cmd(1'b1, 1'b0);
      step(3);
      #2 res = 1'b1;
      #1;
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0000}) begin
         bad++; $display("FAIL async_reset: got %h want %h", snap, {8'h00, 8'h00, 4'b0000});
      end
      #1 res = 1'b0;
      step(12);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0000}) begin
         bad++; $display("FAIL post_reset_idle: got %h want %h", snap, {8'h00, 8'h00, 4'b0000});
      end
   endtask

   task automatic test_load_done;
      do_load(8'h00, 8'h01);
      do_cmd(1'b1, 1'b0);
      step(10);
      total++;
      if (snap !== {8'h00, 8'h00, 4'b0110}) begin
         bad++; $display("FAIL reach_done: got %h want %h", snap, {8'h00, 8'h00, 4'b0110});
      end
      do_load(8'h02, 8'h30);
      total++;
      if (snap !== {8'h02, 8'h30, 4'b0000}) begin
         bad++; $display("FAIL load_in_done: got %h want %h", snap, {8'h02, 8'h30, 4'b0000});
      end
   endtask

   task automatic test_back_to_back;
      do_load(8'h00, 8'h01);
      do_cmd(1'b1, 1'b0);
      step(9);
      do_load(8'h04, 8'h00);
      total++;
      if (snap !== {8'h04, 8'h00, 4'b0000}) begin
         bad++; $display("FAIL load_on_final_tick: got %h want %h", snap, {8'h04, 8'h00, 4'b0000});
      end
      step(3);
      total++;
      if (snap !== {8'h04, 8'h00, 4'b0000}) begin
         bad++; $display("FAIL idle_after_tick_load: got %h want %h", snap, {8'h04, 8'h00, 4'b0000});
      end
   endtask

   initial begin
      test_reset;
      test_borrow;
      test_expire;
      test_pause;
      test_load_err;
      test_reset_run;
      test_load_done;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
